// File: rtl/fp_fixed_pkg.sv
// Shared constants and types for the IEEE-754 single to sign-magnitude Q1.19 converter.
package fp_fixed_pkg;

  localparam int FP_BIAS   = 127;
  localparam int FRAC_W    = 19;
  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int MAX_SHIFT = 21;
  localparam int RES_W     = FRAC_W + 1;
  localparam int CNT_W     = $clog2(MAX_SHIFT + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  typedef struct packed {
    logic              sign;
    logic              int_bit;
    logic [FRAC_W-1:0] frac;
  } fixed_t;

  // Working set of the right-shifter: kept magnitude plus the two rounding bits.
  typedef struct packed {
    logic [RES_W-1:0] res;
    logic             guard;
    logic             sticky;
  } shift_t;

endpackage

// File: rtl/fp_rshift_step.sv
// One combinational right-shift step of the converter; passes its input through when disabled.
module fp_rshift_step
  import fp_fixed_pkg::*;
(
  input  logic   en,
  input  shift_t cur,
  output shift_t nxt
);

  always_comb begin
    // NOTE: the default assignment first keeps this block free of latches on the en=0 path.
    nxt = cur;
    if (en) begin
      nxt.sticky = cur.sticky | cur.guard;
      nxt.guard  = cur.res[0];
      nxt.res    = cur.res >> 1;
    end
  end

endmodule

// File: rtl/fp_to_fixed_seq.sv
// Iterative IEEE-754 single -> sign-magnitude Q1.19 converter with valid/ready on both sides.
// Define FP2FIX_ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates.
module fp_to_fixed_seq
  import fp_fixed_pkg::*;
#(
  parameter int SHIFTS_PER_CYCLE = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [31:0]       fp_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              sign_o,
  output logic              integer_o,
  output logic [FRAC_W-1:0] fractional_o,
  output logic              sat_o,
  output logic              inexact_o
);

`ifdef FP2FIX_ROUND_NEAREST_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] STEP = CNT_W'(SHIFTS_PER_CYCLE);

  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic [EXP_W-1:0]  shift_amt;
  logic [CNT_W-1:0]  n_init;

  assign {in_sign, in_exp, in_mant} = fp_i;
  assign shift_amt = EXP_W'(FP_BIAS) - in_exp;
  assign n_init    = (shift_amt > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT)
                                                     : shift_amt[CNT_W-1:0];

  state_e           state;
  shift_t           work_q;
  logic [CNT_W-1:0] n_q;
  logic             sign_q;
  fixed_t           result_q;

  // Stage k only shifts while more than k steps remain, so a partial last cycle stops exactly.
  shift_t chain [SHIFTS_PER_CYCLE+1];
  assign chain[0] = work_q;

  for (genvar k = 0; k < SHIFTS_PER_CYCLE; k++) begin : g_step
    fp_rshift_step u_step (
      .en  (n_q > CNT_W'(k)),
      .cur (chain[k]),
      .nxt (chain[k+1])
    );
  end

  shift_t           last;
  logic [CNT_W-1:0] n_next;
  logic [RES_W-1:0] rounded;

  assign last    = chain[SHIFTS_PER_CYCLE];
  assign n_next  = (n_q > STEP) ? n_q - STEP : '0;
  // At least one shift has cleared res[19], so a round-up carry lands on exactly 1.0.
  assign rounded = last.res + RES_W'(ROUND_EN & last.guard & (last.sticky | last.res[0]));

  assign sign_o       = result_q.sign;
  assign integer_o    = result_q.int_bit;
  assign fractional_o = result_q.frac;

  // NOTE: state and datapath registers use non-blocking assignments and all reset
  // asynchronously, so every visible output is defined the moment rst_n_i falls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      work_q      <= '0;
      n_q         <= '0;
      sign_q      <= 1'b0;
      result_q    <= '0;
      sat_o       <= 1'b0;
      inexact_o   <= 1'b0;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid_i) begin
            in_ready_o <= 1'b0;
            if (in_exp == '0) begin
              result_q    <= '0;
              sat_o       <= 1'b0;
              inexact_o   <= |in_mant;
              out_valid_o <= 1'b1;
              state       <= DONE;
            end else if (in_exp >= EXP_W'(FP_BIAS)) begin
              // Exact +-1.0, or a clamp for larger magnitudes, Inf and NaN.
              result_q    <= '{sign: in_sign, int_bit: 1'b1, frac: '0};
              sat_o       <= (in_exp != EXP_W'(FP_BIAS)) | (|in_mant);
              inexact_o   <= 1'b0;
              out_valid_o <= 1'b1;
              state       <= DONE;
            end else begin
              work_q <= '{res:    {1'b1, in_mant[MANT_W-1:4]},
                          guard:  in_mant[3],
                          sticky: |in_mant[2:0]};
              n_q    <= n_init;
              sign_q <= in_sign;
              state  <= SHIFT;
            end
          end
        end

        SHIFT: begin
          work_q <= last;
          n_q    <= n_next;
          if (n_next == '0) begin
            result_q    <= '{sign:    sign_q & (|rounded),
                             int_bit: rounded[RES_W-1],
                             frac:    rounded[FRAC_W-1:0]};
            sat_o       <= 1'b0;
            inexact_o   <= last.guard | last.sticky;
            out_valid_o <= 1'b1;
            state       <= DONE;
          end
        end

        DONE: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_to_fixed_seq.sv
// Directed self-checking bench for fp_to_fixed_seq (SHIFTS_PER_CYCLE=1), both rounding builds.
module tb_fp_to_fixed_seq;

  logic        clk_i;
  logic        rst_n_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] fp_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        sign_o;
  logic        integer_o;
  logic [18:0] fractional_o;
  logic        sat_o;
  logic        inexact_o;

  int n_vec;
  int n_miss;

  typedef struct {
    logic [31:0] fp;
    logic [21:0] res;   // {sign, int, frac, sat}
    logic        inx;
    logic        chk_inx;
    int          lat;
  } vec_t;

  fp_to_fixed_seq #(.SHIFTS_PER_CYCLE(1)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .fp_i         (fp_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .sign_o       (sign_o),
    .integer_o    (integer_o),
    .fractional_o (fractional_o),
    .sat_o        (sat_o),
    .inexact_o    (inexact_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  function automatic vec_t mk(input logic [31:0] fp, input logic s, input logic i,
                              input logic [18:0] f, input logic sat, input logic inx,
                              input logic chk, input int lat);
    vec_t v;
    v.fp      = fp;
    v.res     = {s, i, f, sat};
    v.inx     = inx;
    v.chk_inx = chk;
    v.lat     = lat;
    return v;
  endfunction

  // Presents fp, waits for the accept edge, scrambles fp_i, then counts edges to out_valid_o.
  // lat stays -1 when either wait runs out.
  task automatic convert(input logic [31:0] fp, output int lat);
    int wait_cnt;
    lat = -1;
    @(negedge clk_i);
    fp_i       = fp;
    in_valid_i = 1'b1;
    wait_cnt   = 0;
    while (in_ready_o !== 1'b1 && wait_cnt < 50) begin
      @(negedge clk_i);
      wait_cnt++;
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    fp_i       = $urandom;
    if (wait_cnt < 50) begin
      for (int c = 1; c <= 40 && lat < 0; c++) begin
        if (out_valid_o === 1'b1) lat = c;
        else begin
          @(posedge clk_i);
          #1;
        end
      end
    end
  endtask

  task automatic release_out();
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] got;
    rst_n_i     = 1'b0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b0;
    fp_i        = 32'h3F000000;
    repeat (2) @(negedge clk_i);
    got = {in_ready_o, out_valid_o, sign_o, integer_o, fractional_o, sat_o, inexact_o};
    n_vec++;
    if (got !== {1'b1, 24'd0}) begin
      n_miss++;
      $display("FAIL reset_state: got %h expected %h", got, {1'b1, 24'd0});
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic test_conversions();
    vec_t        tbl[$];
    logic [21:0] got;
    int          lat;
    // special cases: one-cycle latency
    tbl.push_back(mk(32'hBF800000, 1, 1, 19'h0, 0, 0, 1, 1));
    tbl.push_back(mk(32'h3F800000, 0, 1, 19'h0, 0, 0, 1, 1));
    tbl.push_back(mk(32'h40000000, 0, 1, 19'h0, 1, 0, 0, 1));
    tbl.push_back(mk(32'h7FC00000, 0, 1, 19'h0, 1, 0, 0, 1));
    tbl.push_back(mk(32'hFF800000, 1, 1, 19'h0, 1, 0, 0, 1));
    tbl.push_back(mk(32'h3F800001, 0, 1, 19'h0, 1, 0, 0, 1));
    tbl.push_back(mk(32'h80000000, 0, 0, 19'h0, 0, 0, 1, 1));
    tbl.push_back(mk(32'h00000001, 0, 0, 19'h0, 0, 1, 1, 1));
    tbl.push_back(mk(32'h807FFFFF, 0, 0, 19'h0, 0, 1, 1, 1));
    // normal path: latency 1 + n
    tbl.push_back(mk(32'h3F000000, 0, 0, 19'h40000, 0, 0, 1, 2));
    tbl.push_back(mk(32'hBF400000, 1, 0, 19'h60000, 0, 0, 1, 2));
    tbl.push_back(mk(32'h3E800000, 0, 0, 19'h20000, 0, 0, 1, 3));
    tbl.push_back(mk(32'h36000000, 0, 0, 19'h00001, 0, 0, 1, 20));
    tbl.push_back(mk(32'hB6000000, 1, 0, 19'h00001, 0, 0, 1, 20));
    tbl.push_back(mk(32'hB5800000, 0, 0, 19'h0, 0, 1, 1, 21));
    tbl.push_back(mk(32'h35000000, 0, 0, 19'h0, 0, 1, 1, 22));
    tbl.push_back(mk(32'hB5000000, 0, 0, 19'h0, 0, 1, 1, 22));
    tbl.push_back(mk(32'h34000000, 0, 0, 19'h0, 0, 1, 1, 22));
    foreach (tbl[i]) begin
      convert(tbl[i].fp, lat);
      got = {sign_o, integer_o, fractional_o, sat_o};
      n_vec++;
      if (got !== tbl[i].res) begin
        n_miss++;
        $display("FAIL conv_result fp=%h: got %h expected %h", tbl[i].fp, got, tbl[i].res);
      end
      if (tbl[i].chk_inx) begin
        n_vec++;
        if (inexact_o !== tbl[i].inx) begin
          n_miss++;
          $display("FAIL conv_inexact fp=%h: got %b expected %b", tbl[i].fp, inexact_o, tbl[i].inx);
        end
      end
      n_vec++;
      if (lat != tbl[i].lat) begin
        n_miss++;
        $display("FAIL conv_latency fp=%h: got %0d expected %0d", tbl[i].fp, lat, tbl[i].lat);
      end
      release_out();
    end
  endtask

  task automatic test_rounding();
    vec_t        tbl[$];
    logic [21:0] got;
    int          lat;
    logic        rn;
`ifdef FP2FIX_ROUND_NEAREST_EN
    rn = 1'b1;
`else
    rn = 1'b0;
`endif
    tbl.push_back(mk(32'h3F000018, 0, 0, rn ? 19'h40001 : 19'h40000, 0, 1, 1, 2));
    tbl.push_back(mk(32'h3F000010, 0, 0, 19'h40000, 0, 1, 1, 2));
    tbl.push_back(mk(32'h3F000030, 0, 0, rn ? 19'h40002 : 19'h40001, 0, 1, 1, 2));
    tbl.push_back(mk(32'h3F000008, 0, 0, 19'h40000, 0, 1, 1, 2));
    tbl.push_back(mk(32'h3F7FFFFF, 0, rn, rn ? 19'h0 : 19'h7FFFF, 0, 1, 1, 2));
    tbl.push_back(mk(32'hB5C00000, rn, 0, rn ? 19'h1 : 19'h0, 0, 1, 1, 21));
    foreach (tbl[i]) begin
      convert(tbl[i].fp, lat);
      got = {sign_o, integer_o, fractional_o, sat_o};
      n_vec++;
      if (got !== tbl[i].res) begin
        n_miss++;
        $display("FAIL round_result fp=%h: got %h expected %h", tbl[i].fp, got, tbl[i].res);
      end
      n_vec++;
      if (inexact_o !== tbl[i].inx) begin
        n_miss++;
        $display("FAIL round_inexact fp=%h: got %b expected %b", tbl[i].fp, inexact_o, tbl[i].inx);
      end
      n_vec++;
      if (lat != tbl[i].lat) begin
        n_miss++;
        $display("FAIL round_latency fp=%h: got %0d expected %0d", tbl[i].fp, lat, tbl[i].lat);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [24:0] got;
    logic [24:0] exp_hold;
    int          lat;
    exp_hold = {1'b1, 1'b0, 1'b0, 1'b0, 19'h60000, 1'b0, 1'b0};
    convert(32'hBF400000 & 32'h7FFFFFFF, lat);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_i);
      #1;
      got = {out_valid_o, in_ready_o, sign_o, integer_o, fractional_o, sat_o, inexact_o};
      n_vec++;
      if (got !== exp_hold) begin
        n_miss++;
        $display("FAIL bp_hold cycle %0d: got %h expected %h", i, got, exp_hold);
      end
    end
    // release while a new input is already waiting
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    fp_i        = 32'h3E800000;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    n_vec++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_miss++;
      $display("FAIL bp_bubble: got %b expected 01", {out_valid_o, in_ready_o});
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    n_vec++;
    if (in_ready_o !== 1'b0) begin
      n_miss++;
      $display("FAIL bp_accept: in_ready got %b expected 0", in_ready_o);
    end
    lat = -1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      if (out_valid_o === 1'b1) lat = c;
      else begin
        @(posedge clk_i);
        #1;
      end
    end
    n_vec++;
    if (lat != 3 || fractional_o !== 19'h20000) begin
      n_miss++;
      $display("FAIL bp_next_result: got lat %0d frac %h expected lat 3 frac 20000", lat, fractional_o);
    end
    // result stays pending so the reset test sees nonzero outputs cleared
  endtask

  task automatic test_back_to_back();
    logic [4:0] got;
    release_out();
    @(negedge clk_i);
    out_ready_i = 1'b1;
    in_valid_i  = 1'b1;
    fp_i        = 32'hBF800000;
    @(posedge clk_i);
    #1;
    got = {out_valid_o, in_ready_o, sign_o, integer_o, sat_o};
    n_vec++;
    if (got !== 5'b10110) begin
      n_miss++;
      $display("FAIL b2b_first: got %b expected 10110", got);
    end
    fp_i = 32'h40000000;
    @(posedge clk_i);
    #1;
    n_vec++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_miss++;
      $display("FAIL b2b_bubble: got %b expected 01", {out_valid_o, in_ready_o});
    end
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    got = {out_valid_o, in_ready_o, sign_o, integer_o, sat_o};
    n_vec++;
    if (got !== 5'b10011) begin
      n_miss++;
      $display("FAIL b2b_second: got %b expected 10011", got);
    end
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    n_vec++;
    if ({out_valid_o, in_ready_o} !== 2'b01) begin
      n_miss++;
      $display("FAIL b2b_idle: got %b expected 01", {out_valid_o, in_ready_o});
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [24:0] got;
    logic [21:0] res;
    int          lat;
    // prior result (0.25) is still held at this point; put one more through first
    release_out();
    @(negedge clk_i);
    fp_i       = 32'h3A800000;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    n_vec++;
    if ({out_valid_o, in_ready_o} !== 2'b00) begin
      n_miss++;
      $display("FAIL rst_busy: got %b expected 00", {out_valid_o, in_ready_o});
    end
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    got = {in_ready_o, out_valid_o, sign_o, integer_o, fractional_o, sat_o, inexact_o};
    n_vec++;
    if (got !== {1'b1, 24'd0}) begin
      n_miss++;
      $display("FAIL rst_mid_shift: got %h expected %h", got, {1'b1, 24'd0});
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    convert(32'hBF000000, lat);
    res = {sign_o, integer_o, fractional_o, sat_o};
    n_vec++;
    if (res !== {1'b1, 1'b0, 19'h40000, 1'b0} || lat != 2) begin
      n_miss++;
      $display("FAIL rst_recover: got %h lat %0d expected %h lat 2", res, lat,
               {1'b1, 1'b0, 19'h40000, 1'b0});
    end
    release_out();
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    test_reset();
    test_conversions();
    test_rounding();
    test_backpressure();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
